// File: rtl/bench_sequencer_if.sv
// Harness-side bundle between the benchmark sequencer and the wrapper it exercises.
// dbg_state mirrors the sequencer FSM so checkers can bind to it.
interface bench_sequencer_if;
    logic       start;
    logic [7:0] dut_out;
    logic [2:0] sel;
    logic [2:0] stim;
    logic       dut_reset_n;
    logic       busy;
    logic       done;
    logic [7:0] signature;
    logic [2:0] dbg_state;

    // start is a level sampled only while idle; done is a single-cycle pulse
    // that closes a sweep, and busy covers every cycle of the sweep including it.
    modport master (
        output start, dut_out,
        input  sel, stim, dut_reset_n, busy, done, signature, dbg_state
    );

    modport slave (
        input  start, dut_out,
        output sel, stim, dut_reset_n, busy, done, signature, dbg_state
    );
endinterface

// File: rtl/bench_sequencer.sv
// Automatic sweep of the wrapper's enabled benchmark slots, folding each slot's
// output into one rotate-XOR signature.
module bench_sequencer #(
    parameter int         SETTLE_CYCLES = 2,
    parameter int         DWELL_CYCLES  = 16,
    parameter logic [7:0] SLOT_MASK     = 8'hFF
) (
    input logic               clk,
    input logic               reset_n,
    bench_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SETTLE, RUN, NEXT, DONE} state_t;

    localparam int MAX_CNT = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);

    state_t           state;
    logic [2:0]       slot;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       sel;
    logic [2:0]       stim;
    logic             dut_reset_n;
    logic             busy;
    logic             done;
    logic [7:0]       signature;
    logic [3:0]       first_slot;
    logic [3:0]       next_slot;

    // Lowest enabled slot at or above lo; 8 means none, so the slot never wraps.
    function automatic logic [3:0] lowest_from(input logic [3:0] lo);
        logic [3:0] r;
        r = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (SLOT_MASK[i] && (4'(i) >= lo)) r = 4'(i);
        end
        return r;
    endfunction

    always_comb begin
        first_slot = lowest_from(4'd0);
        next_slot  = lowest_from({1'b0, slot} + 4'd1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            slot        <= 3'd0;
            cnt         <= '0;
            sel         <= 3'd0;
            stim        <= 3'd0;
            dut_reset_n <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            signature   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    sel         <= 3'd0;
                    stim        <= 3'd0;
                    dut_reset_n <= 1'b1;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    cnt         <= '0;
                    if (bus.start) begin
                        signature <= 8'd0;
                        busy      <= 1'b1;
                        if (first_slot[3]) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            slot        <= first_slot[2:0];
                            sel         <= first_slot[2:0];
                            dut_reset_n <= 1'b0;
                            state       <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    // The local reset is only held for the first settle cycle.
                    dut_reset_n <= 1'b1;
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        stim  <= 3'd0;
                        state <= RUN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    signature <= {signature[6:0], signature[7]} ^ bus.dut_out;
                    if (cnt == DWELL_LAST) begin
                        cnt   <= '0;
                        stim  <= 3'd0;
                        state <= NEXT;
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                        stim <= stim + 3'd1;
                    end
                end
                NEXT: begin
                    if (!next_slot[3]) begin
                        slot        <= next_slot[2:0];
                        sel         <= next_slot[2:0];
                        dut_reset_n <= 1'b0;
                        state       <= SETTLE;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    sel   <= 3'd0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sel         = sel;
    assign bus.stim        = stim;
    assign bus.dut_reset_n = dut_reset_n;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.signature   = signature;
    assign bus.dbg_state   = state;
endmodule

// File: tb/tb_bench_sequencer.sv
// Cycle-level scoreboard for bench_sequencer across several parameter sets,
// each instance driving a small fake wrapper whose output depends on age since reset.
module tb_bench_sequencer;
    localparam int N = 5;
    localparam int         SET_P  [N] = '{2, 2, 2, 2, 1};
    localparam int         DW_P   [N] = '{4, 4, 4, 16, 1};
    localparam logic [7:0] MASK_P [N] = '{8'h01, 8'hA0, 8'h00, 8'hFF, 8'h81};

    typedef struct packed {
        logic [2:0] sel;
        logic       sel_dc;
        logic [2:0] stim;
        logic       rst_n;
        logic       busy;
        logic       done;
        logic [7:0] sig;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         armed = 1'b0;
    logic [N-1:0] start_v = '0;
    logic [7:0]   tbl [64];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int g, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %02h expected %02h at %0t", name, g, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int s, input bit dc, input int st, input bit rst,
                                input bit bsy, input bit dn, input logic [7:0] sig);
        exp_t e;
        e.sel    = 3'(s);
        e.sel_dc = dc;
        e.stim   = 3'(st);
        e.rst_n  = rst;
        e.busy   = bsy;
        e.done   = dn;
        e.sig    = sig;
        return e;
    endfunction

    // What the fake wrapper shows for a slot/stimulus after `age` cycles out of reset.
    function automatic logic [7:0] model_out(input int g, input int s, input int st, input int age);
        if (g == 0) return 8'h01;
        return tbl[s * 8 + st] ^ 8'(age);
    endfunction

    for (genvar g = 0; g < N; g++) begin : inst
        bench_sequencer_if bus();
        logic [7:0] age = 8'd0;
        logic [7:0] last_sig = 8'd0;
        exp_t       exp_q[$];
        exp_t       e;

        assign bus.start   = start_v[g];
        assign bus.dut_out = (g == 0) ? 8'h01 : (tbl[{bus.sel, bus.stim}] ^ age);
        always @(posedge clk) age <= bus.dut_reset_n ? age + 8'd1 : 8'd0;

        bench_sequencer #(
            .SETTLE_CYCLES(SET_P[g]),
            .DWELL_CYCLES (DW_P[g]),
            .SLOT_MASK    (MASK_P[g])
        ) dut (
            .clk    (clk),
            .reset_n(reset_n),
            .bus    (bus)
        );

        // Whole-sweep expectation: one entry per cycle after the accepting edge.
        task automatic build();
            logic [7:0] sig;
            sig = 8'd0;
            for (int s = 0; s < 8; s++) begin
                if (MASK_P[g][s]) begin
                    for (int i = 0; i < SET_P[g]; i++)
                        exp_q.push_back(mk(s, 1'b0, 0, i != 0, 1'b1, 1'b0, sig));
                    for (int r = 0; r < DW_P[g]; r++) begin
                        exp_q.push_back(mk(s, 1'b0, r % 8, 1'b1, 1'b1, 1'b0, sig));
                        sig = {sig[6:0], sig[7]} ^ model_out(g, s, r % 8, SET_P[g] - 1 + r);
                    end
                    exp_q.push_back(mk(s, 1'b0, 0, 1'b1, 1'b1, 1'b0, sig));
                end
            end
            exp_q.push_back(mk(0, 1'b1, 0, 1'b1, 1'b1, 1'b1, sig));
            exp_q.push_back(mk(0, 1'b0, 0, 1'b1, 1'b0, 1'b0, sig));
            last_sig = sig;
        endtask

        always @(posedge clk) begin
            if (!reset_n) begin
                exp_q.delete();
                last_sig = 8'd0;
            end else if (start_v[g] && exp_q.size() == 0) begin
                build();
            end
        end

        always @(negedge clk) begin
            if (armed) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = mk(0, 1'b0, 0, 1'b1, 1'b0, 1'b0, last_sig);
                if (!e.sel_dc) check("sel", g, 8'(bus.sel), 8'(e.sel));
                check("stim", g, 8'(bus.stim), 8'(e.stim));
                check("dut_reset_n", g, 8'(bus.dut_reset_n), 8'(e.rst_n));
                check("busy", g, 8'(bus.busy), 8'(e.busy));
                check("done", g, 8'(bus.done), 8'(e.done));
                check("signature", g, bus.signature, e.sig);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [N-1:0] m);
        start_v = m;
        tick(1);
        start_v = '0;
    endtask

    function automatic int pending();
        return inst[0].exp_q.size() + inst[1].exp_q.size() + inst[2].exp_q.size()
             + inst[3].exp_q.size() + inst[4].exp_q.size();
    endfunction

    task automatic wait_all(input int budget);
        int n;
        n = 0;
        while (pending() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (pending() != 0) begin
            errors++;
            $display("FAIL sweep_timeout got %0d pending expected 0 at %0t", pending(), $time);
        end
    endtask

    initial begin
        void'($urandom(32'd20240611));
        for (int i = 0; i < 64; i++) tbl[i] = 8'($urandom);

        tick(3);
        armed = 1'b1;
        reset_n = 1'b1;
        tick($urandom_range(1, 4));

        pulse('1);
        wait_all(400);
        check("golden_single", 0, inst[0].bus.signature, 8'h0F);

        // Extra start pulses while sweeps are in flight must be ignored.
        pulse('1);
        tick(4);
        pulse('1);
        tick(20);
        pulse(5'b01000);
        wait_all(400);

        // Start held high re-launches on the first idle cycle after done.
        start_v = '1;
        tick(200);
        start_v = '0;
        wait_all(400);

        // Reset lands inside the RUN phase of slot 3 of the full sweep.
        pulse('1);
        tick(64);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(2);
        pulse('1);
        wait_all(400);

        repeat (8) begin
            pulse(5'($urandom_range(0, 31)));
            tick($urandom_range(0, 60));
            if ($urandom_range(0, 3) == 0) begin
                reset_n = 1'b0;
                tick(1);
                reset_n = 1'b1;
            end
        end
        wait_all(400);
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish expected finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
